seq_detect_param: RTL and testbench
===================================

# seq_detect_param

Parametrised, runtime-programmable serial bit-sequence detector. It generalises the fixed-pattern Moore detectors in the design library to any pattern of 1..MAX_LEN bits, with overlapping or non-overlapping detection selected at run time. It adds an input-valid qualifier, a registered match pulse and a saturating match counter. The block sits on a serial data path and flags pattern occurrences to downstream control or status logic.

## Interface
- MAX_LEN, default 8: maximum pattern length in bits; legal range ≥ 2.
- CNT_W, default 16: width of the match counter.
- LEN_W, derived as $clog2(MAX_LEN+1): width of cfg_len.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- cfg_load  in  1  one-cycle strobe that captures cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern  in  MAX_LEN  pattern bits. Bit [cfg_len-1] is the first bit received; bit [0] is the last.
- cfg_len  in  LEN_W  pattern length.
- cfg_overlap  in  1  1 selects overlapping detection; 0 selects non-overlapping.
- in_valid  in  1  qualifies x; x is sampled only when in_valid=1.
- x  in  1  serial data bit.
- match  out  1  registered one-cycle pulse per detected occurrence.
- match_count  out  CNT_W  number of matches since reset or the last cfg_load; saturates at the maximum value.
- cfg_err  out  1  high while the active configuration is illegal.

## Operation
- Internal state:
  - pattern register pat_r, length register len_r, mode register ovl_r.
  - History shift register hist (MAX_LEN bits). The newest bit enters at [0].
  - Fill counter fill (LEN_W bits): number of valid bits accumulated, saturating at MAX_LEN.
- Reset values: pat_r=0, len_r=0, ovl_r=1, hist=0, fill=0, match=0, match_count=0, cfg_err=1. The detector is idle until the first cfg_load.
- cfg_load=1 at an edge:
  - Load pat_r, len_r and ovl_r.
  - Clear hist, fill, match and match_count.
  - Set cfg_err = (cfg_len==0) or (cfg_len>MAX_LEN).
  - Discard x, even if in_valid=1 in the same cycle. cfg_load takes priority.
- in_valid=1, cfg_load=0, cfg_err=0 at an edge:
  - hist_n = {hist[MAX_LEN-2:0], x}.
  - fill_n = min(fill+1, MAX_LEN).
  - hit = (fill_n ≥ len_r) and (hist_n[len_r-1:0] == pat_r[len_r-1:0]). Bits above len_r-1 are ignored.
  - match <= hit.
  - If hit and ovl_r=1: hist <= hist_n, fill <= fill_n. The suffix of the matched bits may begin the next match.
  - If hit and ovl_r=0: hist <= hist_n, fill <= 0. A full len_r new bits are needed before the next match.
  - If no hit: hist <= hist_n, fill <= fill_n.
  - If hit, match_count increments, holding at 2^CNT_W-1.
- in_valid=0 (no cfg_load): hist, fill and match_count hold; match <= 0.
- cfg_err=1: input bits are ignored, match stays 0, match_count holds at 0.
- Equivalent Moore view: the states are fill level × history. The output depends only on registered state.

## Timing
- Latency: match is high for exactly the one clk cycle following the edge that samples the final pattern bit.
- Back-to-back matches are possible in overlap mode, e.g. pattern 11 on a stream of 1s. In that case match stays high on consecutive cycles, one cycle per match.
- match_count updates on the same edge as match, so both are coherent in the same cycle.
- cfg_load takes effect at its edge. match is 0 in the following cycle.
- Asynchronous reset mid-stream clears all state immediately. The first match after release requires a new cfg_load followed by a full pattern.
- Changes on the cfg_* inputs have no effect without cfg_load.

## Test plan
- Overlap, pattern 1001 (cfg_len=4, cfg_pattern=8'h09), in_valid=1, stream 1,0,0,1,0,0,1 -> match high after the 4th and the 7th bits; match_count=2.
- Same stream with cfg_overlap=0 -> match high only after the 4th bit; match_count=1.
- Overlap, pattern 101 with in_valid=0 gaps of 3 cycles between every bit -> matches identical to the gap-free case; match=0 during gaps and never lasts more than one cycle.
- cfg_load with cfg_len=0 or cfg_len=MAX_LEN+1 -> cfg_err=1; a stream containing any pattern gives match=0 and match_count=0. A later legal cfg_load clears cfg_err.
- CNT_W=2, pattern 11, overlap, eight 1s -> seven matches; match_count saturates at 3 while match still pulses each cycle. cfg_load with in_valid=1 in the same cycle -> count=0 and the bit is dropped.
- Pattern at full length MAX_LEN (10110011 for MAX_LEN=8) -> single match after the 8th bit. rst_n asserted after 5 bits, then released, then a cfg_load and the full pattern -> exactly one match, none from the pre-reset bits.

Source files
------------

// File: rtl/seq_detect_param.sv
// Runtime-programmable serial bit-sequence detector with overlap/non-overlap modes,
// input-valid qualifier, registered match pulse and saturating match counter.
module seq_detect_param #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               x,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err
);

    // One extra bit so fill+1 cannot wrap when MAX_LEN+1 is a power of two.
    localparam logic [LEN_W:0] MAX_L = (LEN_W + 1)'(MAX_LEN);

    logic [MAX_LEN-1:0] pat_r;
    logic [MAX_LEN-1:0] hist;
    logic [MAX_LEN-1:0] hist_n;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   len_r;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W:0]     fill_inc;
    logic [LEN_W:0]     fill_n;
    logic               ovl_r;
    logic               hit;

    always_comb begin
        hist_n   = {hist[MAX_LEN-2:0], x};
        fill_inc = {1'b0, fill} + (LEN_W + 1)'(1);
        fill_n   = (fill_inc > MAX_L) ? MAX_L : fill_inc;
        mask     = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_r));
        end
        hit = (fill_n >= {1'b0, len_r}) && (((hist_n ^ pat_r) & mask) == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_r       <= '0;
            len_r       <= '0;
            ovl_r       <= 1'b1;
            hist        <= '0;
            fill        <= '0;
            match       <= 1'b0;
            match_count <= '0;
            cfg_err     <= 1'b1;
        end else if (cfg_load) begin
            pat_r       <= cfg_pattern;
            len_r       <= cfg_len;
            ovl_r       <= cfg_overlap;
            hist        <= '0;
            fill        <= '0;
            match       <= 1'b0;
            match_count <= '0;
            cfg_err     <= (cfg_len == '0) || ({1'b0, cfg_len} > MAX_L);
        end else if (in_valid && !cfg_err) begin
            hist  <= hist_n;
            // Non-overlap restarts the fill so a fresh len_r bits are required.
            fill  <= (hit && !ovl_r) ? '0 : fill_n[LEN_W-1:0];
            match <= hit;
            if (hit && (match_count != '1)) begin
                match_count <= match_count + CNT_W'(1);
            end
        end else begin
            match <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench: a bit-list reference model pushes expected outputs per cycle,
// a monitor pops and compares them after each rising edge.
module tb_seq_detect_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_load;
    logic [7:0]  cfg_pattern;
    logic [3:0]  cfg_len;
    logic        cfg_overlap;
    logic        in_valid;
    logic        x;
    logic        match_a, err_a, match_b, err_b;
    logic [15:0] count_a;
    logic [1:0]  count_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_detect_param #(.MAX_LEN(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .x(x),
        .match(match_a), .match_count(count_a), .cfg_err(err_a)
    );

    seq_detect_param #(.MAX_LEN(8), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .x(x),
        .match(match_b), .match_count(count_b), .cfg_err(err_b)
    );

    typedef struct {
        bit m;
        int c16;
        int c2;
        bit err;
    } exp_t;

    exp_t sb[$];

    // Reference model: loaded config plus the list of bits seen since the last restart.
    bit [7:0] m_pat;
    int       m_len;
    bit       m_ovl;
    bit       m_err;
    bit       seen[$];
    int       m_c16, m_c2;

    function automatic void chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_pat = 8'h00;
        m_len = 0;
        m_ovl = 1'b1;
        m_err = 1'b1;
        seen.delete();
        m_c16 = 0;
        m_c2  = 0;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("match", match_a, e.m);
            chk("match_count", count_a, e.c16);
            chk("cfg_err", err_a, e.err);
            chk("match_small", match_b, e.m);
            chk("match_count_sat", count_b, e.c2);
        end
    end

    task automatic step(input bit ld, input logic [7:0] p, input int l, input bit o,
                        input bit v, input bit xb);
        exp_t e;
        bit   hit;
        @(negedge clk);
        cfg_load = ld;
        if (ld) begin
            cfg_pattern = p;
            cfg_len     = 4'(l);
            cfg_overlap = o;
        end else begin
            cfg_pattern = 8'($urandom);
            cfg_len     = 4'($urandom);
            cfg_overlap = 1'($urandom);
        end
        in_valid = v;
        x        = xb;

        e.m = 1'b0;
        if (ld) begin
            m_pat = p;
            m_len = l;
            m_ovl = o;
            m_err = (l == 0) || (l > 8);
            seen.delete();
            m_c16 = 0;
            m_c2  = 0;
        end else if (v && !m_err) begin
            seen.push_back(xb);
            if (seen.size() > 8) void'(seen.pop_front());
            hit = (seen.size() >= m_len);
            if (hit) begin
                for (int k = 0; k < m_len; k++) begin
                    if (seen[seen.size() - 1 - k] != m_pat[k]) hit = 1'b0;
                end
            end
            if (hit) begin
                e.m   = 1'b1;
                m_c16 = (m_c16 < 65535) ? m_c16 + 1 : m_c16;
                m_c2  = (m_c2 < 3) ? m_c2 + 1 : m_c2;
                if (!m_ovl) seen.delete();
            end
        end
        e.c16 = m_c16;
        e.c2  = m_c2;
        e.err = m_err;
        sb.push_back(e);
    endtask

    task automatic load(input logic [7:0] p, input int l, input bit o);
        step(1'b1, p, l, o, 1'b0, 1'b0);
    endtask

    // Sends bits[n-1] first, with 'gap' idle cycles after each bit.
    task automatic send(input logic [7:0] bits, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b0, 8'h00, 0, 1'b0, 1'b1, bits[i]);
            repeat (gap) step(1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic idle_drain();
        @(negedge clk);
        cfg_load = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_match"}, match_a, 0);
        chk({tag, "_count"}, count_a, 0);
        chk({tag, "_err"}, err_a, 1);
        chk({tag, "_count_s"}, count_b, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int l;
        rst_n       = 1'b0;
        cfg_load    = 1'b0;
        cfg_pattern = 8'h00;
        cfg_len     = 4'd0;
        cfg_overlap = 1'b0;
        in_valid    = 1'b0;
        x           = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Idle until first load: bits ignored.
        send(8'hFF, 4, 0);

        // 1001 overlapping on 1,0,0,1,0,0,1
        load(8'h09, 4, 1'b1);
        send(8'h49, 7, 0);
        idle_drain();
        chk("ovl_1001_count", count_a, 2);

        load(8'h09, 4, 1'b0);
        send(8'h49, 7, 0);
        idle_drain();
        chk("novl_1001_count", count_a, 1);

        // 101 overlapping, with 3-cycle gaps: 1,0,1,0,1
        load(8'h05, 3, 1'b1);
        send(8'h15, 5, 3);
        idle_drain();
        chk("gap_101_count", count_a, 2);

        // Illegal lengths
        load(8'h01, 0, 1'b1);
        send(8'hFF, 8, 0);
        idle_drain();
        chk("len0_err", err_a, 1);
        chk("len0_count", count_a, 0);
        load(8'h01, 9, 1'b1);
        send(8'hFF, 8, 0);
        idle_drain();
        chk("len9_err", err_a, 1);
        load(8'h03, 2, 1'b1);
        idle_drain();
        chk("legal_clears_err", err_a, 0);

        // Saturation on the 2-bit counter: 11 over eight 1s
        send(8'hFF, 8, 0);
        idle_drain();
        chk("sat_count_wide", count_a, 7);
        chk("sat_count_narrow", count_b, 3);
        step(1'b1, 8'h03, 2, 1'b1, 1'b1, 1'b1);
        send(8'h01, 1, 0);
        idle_drain();
        chk("load_drops_bit_count", count_a, 0);

        // Full-length pattern, then mid-stream reset
        load(8'hB3, 8, 1'b1);
        send(8'hB3, 8, 0);
        idle_drain();
        chk("full_len_count", count_a, 1);
        load(8'hB3, 8, 1'b1);
        send(8'h16, 5, 0);
        do_reset();
        send(8'h13, 3, 0);
        load(8'hB3, 8, 1'b1);
        send(8'hB3, 8, 0);
        idle_drain();
        chk("post_reset_count", count_a, 1);

        // Randomized traffic with occasional reloads
        load(8'($urandom), 3, 1'b1);
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                l = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 9))
                                                : int'($urandom_range(1, 4));
                step(1'b1, 8'($urandom), l, 1'($urandom), 1'($urandom), 1'($urandom));
            end else begin
                step(1'b0, 8'h00, 0, 1'b0, ($urandom_range(0, 3) != 0), 1'($urandom));
            end
        end
        idle_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
